// File: rtl/ipsxe_floating_point_skid_buf_v1_0_pkg.sv
// Shared floating-point definitions: skid buffer state encoding.
// The encoding doubles as the occupancy count (number of held words).
package ipsxe_floating_point_skid_buf_v1_0_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/ipsxe_floating_point_skid_buf_v1_0.sv
// Two-entry skid buffer in front of the operand register stage.
// Every output comes straight from a flop (or a decode of the state flop).
module ipsxe_floating_point_skid_buf_v1_0
    import ipsxe_floating_point_skid_buf_v1_0_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_aclken,
    input  logic         i_s_tvalid,
    output logic         o_s_tready,
    input  logic [N-1:0] i_s_tdata,
    output logic         o_m_tvalid,
    input  logic         i_m_tready,
    output logic [N-1:0] o_m_tdata,
    output logic [1:0]   o_count
);

    skid_state_t  state_reg, state_next;
    logic [N-1:0] main_reg, main_next;
    logic [N-1:0] skid_reg, skid_next;
    logic         s_tready_reg;
    logic         in_xfer;
    logic         out_xfer;

    assign o_m_tvalid = (state_reg != SKID_EMPTY);
    assign o_count    = state_reg;
    assign o_m_tdata  = main_reg;
    assign o_s_tready = s_tready_reg;

    assign in_xfer  = i_aclken & i_s_tvalid & s_tready_reg;
    assign out_xfer = i_aclken & o_m_tvalid & i_m_tready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            SKID_EMPTY: begin
                if (in_xfer) begin
                    state_next = SKID_ONE;
                    main_next  = i_s_tdata;
                end
            end
            SKID_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_next = i_s_tdata;
                end else if (in_xfer) begin
                    state_next = SKID_FULL;
                    skid_next  = i_s_tdata;
                end else if (out_xfer) begin
                    state_next = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // Upstream is stalled here, so only a drain can happen.
                if (out_xfer) begin
                    state_next = SKID_ONE;
                    main_next  = skid_reg;
                end
            end
            default: begin
                state_next = SKID_EMPTY;
            end
        endcase
    end

    // Ready tracks the next state unconditionally: with the enable low the
    // state holds, so this only changes anything on the first edge out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= SKID_EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            s_tready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            main_reg     <= main_next;
            skid_reg     <= skid_next;
            s_tready_reg <= (state_next != SKID_FULL);
        end
    end

endmodule
